regfile_multiport: RTL and testbench

Parametrised multi-port register file for the RV32I core and later variants: one write port, NUM_READ synchronous read ports, and an optional hardwired-zero entry 0. Write-to-read forwarding is selectable. A sequential clear engine zeroes the array one entry per cycle, after reset or on request, so the storage can map onto RAM. It sits in the decode stage; rdata feeds the execute-stage operand muxes.

---
 rtl/regfile_multiport_if.sv | 43 ++++
 rtl/regfile_multiport.sv | 174 +++++++++++++++++
 tb/tb_regfile_multiport.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_multiport_if.sv
// -----------------------------------------------------------------------------
// regfile_multiport_if
//   Bundles the data-path signals of regfile_multiport: the write port, the
//   NUM_READ read ports, the clear request and the busy flag.
//
//   master : the client (decode stage / testbench). It drives the write
//            port, the read requests and clear_req. It samples rdata and busy.
//   slave  : the register file itself.
//
//   Signals
//     we, waddr, wdata   write enable, address, data
//     re                 per-port read enable (bit i = port i)
//     raddr              packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//     rdata              packed registered read data, port i at [i*WIDTH +: WIDTH]
//     clear_req          one-cycle request to zero the whole array
//     busy               high while the clear engine runs
// -----------------------------------------------------------------------------
interface regfile_multiport_if #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int NUM_READ = 2
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic                         we;
  logic [ADDR_W-1:0]            waddr;
  logic [WIDTH-1:0]             wdata;
  logic [NUM_READ-1:0]          re;
  logic [NUM_READ*ADDR_W-1:0]   raddr;
  logic [NUM_READ*WIDTH-1:0]    rdata;
  logic                         clear_req;
  logic                         busy;

  modport master (
    output we, waddr, wdata, re, raddr, clear_req,
    input  rdata, busy
  );

  modport slave (
    input  we, waddr, wdata, re, raddr, clear_req,
    output rdata, busy
  );
endinterface

// File: rtl/regfile_multiport.sv
// -----------------------------------------------------------------------------
// regfile_multiport
//   Multi-port register file with one write port and NUM_READ registered
//   read ports. Entry 0 can optionally be hardwired to zero. A same-cycle write
//   can optionally be forwarded to a matching read (write-first). Without
//   forwarding, a read returns the pre-edge contents (read-first).
//
//   A sequential clear engine zeroes the array one entry per cycle. It runs
//   after every reset and on clear_req. The storage has no reset of its own,
//   so it can map onto RAM. While the clear engine runs, writes are ignored
//   and every read port loads zero.
//
//   Ports
//     clk   rising-edge clock for all state
//     rst   synchronous, active-high reset; restarts the clear engine
//     bus   regfile_multiport_if.slave (write port, read ports,
//           clear_req, busy)
//
//   The interface instance must be built with the same WIDTH, DEPTH and
//   NUM_READ as this module.
// -----------------------------------------------------------------------------
module regfile_multiport #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int NUM_READ = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input logic                 clk,
  input logic                 rst,
  regfile_multiport_if.slave  bus
);

  localparam int ADDR_W = $clog2(DEPTH);

  // The address compare is one bit wider than the address. This keeps
  // "addr < DEPTH" meaningful when DEPTH is not a power of two, and harmless
  // when it is.
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t            state_reg;
  logic [ADDR_W-1:0] ptr_reg;
  logic              busy_reg;

  // Storage: no reset, single write port, so it can map onto RAM.
  logic [WIDTH-1:0]  mem [DEPTH];

  // ---------------------------------------------------------------------------
  // Write qualification
  // ---------------------------------------------------------------------------
  logic waddr_in_range;
  logic waddr_is_zero_reg;
  logic user_write;     // a client write that will actually land this edge
  logic clear_write;    // the clear engine zeroing entry ptr_reg this edge

  assign waddr_in_range    = ({1'b0, bus.waddr} < DEPTH_EXT);
  assign waddr_is_zero_reg = (ZERO_REG != 0) && (bus.waddr == '0);

  // A clear_req arriving in IDLE drops a write issued in the same cycle. Reset
  // overrides everything.
  assign user_write  = !rst && (state_reg == IDLE) && bus.we && !bus.clear_req
                       && waddr_in_range && !waddr_is_zero_reg;
  assign clear_write = !rst && (state_reg == CLEAR);

  // The single physical write port is shared between the clear engine and the
  // client. The two sources are mutually exclusive by state.
  logic              mem_we_next;
  logic [ADDR_W-1:0] mem_addr_next;
  logic [WIDTH-1:0]  mem_wdata_next;

  always_comb begin
    mem_we_next    = 1'b0;
    mem_addr_next  = bus.waddr;
    mem_wdata_next = bus.wdata;
    if (clear_write) begin
      mem_we_next    = 1'b1;
      mem_addr_next  = ptr_reg;
      mem_wdata_next = '0;
    end else if (user_write) begin
      mem_we_next    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we_next) begin
      mem[mem_addr_next] <= mem_wdata_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Clear engine FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= CLEAR;
      ptr_reg   <= '0;
      busy_reg  <= 1'b1;
    end else begin
      case (state_reg)
        CLEAR: begin
          // The edge that zeroes the last entry also ends the clear.
          if (ptr_reg == LAST_ADDR) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
            busy_reg  <= 1'b0;
          end else begin
            ptr_reg   <= ptr_reg + ADDR_W'(1);
          end
        end
        IDLE: begin
          if (bus.clear_req) begin
            state_reg <= CLEAR;
            ptr_reg   <= '0;
            busy_reg  <= 1'b1;
          end
        end
        default: begin
          state_reg <= CLEAR;
          ptr_reg   <= '0;
          busy_reg  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.busy = busy_reg;

  // ---------------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_READ; gi++) begin : g_read
      logic [ADDR_W-1:0] addr;
      logic [WIDTH-1:0]  rdata_next;
      logic [WIDTH-1:0]  rdata_reg;

      assign addr = bus.raddr[gi*ADDR_W +: ADDR_W];

      // Priority: out of range, hardwired zero, forwarded write, array.
      // user_write is already false for a dropped write (zero entry, range,
      // clear_req), so the forward never leaks a dropped value.
      always_comb begin
        rdata_next = '0;
        if ({1'b0, addr} >= DEPTH_EXT) begin
          rdata_next = '0;
        end else if ((ZERO_REG != 0) && (addr == '0)) begin
          rdata_next = '0;
        end else if ((BYPASS != 0) && user_write && (bus.waddr == addr)) begin
          rdata_next = bus.wdata;
        end else begin
          rdata_next = mem[addr];
        end
      end

      always_ff @(posedge clk) begin
        if (rst || (state_reg == CLEAR)) begin
          rdata_reg <= '0;
        end else if (bus.re[gi]) begin
          rdata_reg <= rdata_next;
        end
      end

      assign bus.rdata[gi*WIDTH +: WIDTH] = rdata_reg;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_multiport.sv
// -----------------------------------------------------------------------------
// tb_regfile_multiport
//   Two register files are driven side by side:
//     A: DEPTH 32, 2 read ports, entry 0 hardwired to zero, write-first forwarding
//     B: DEPTH 20, 3 read ports, no zero entry, read-first
//   A driver applies directed sequences, then random traffic. After each
//   cycle's inputs are set, it pushes the expected post-edge outputs into a
//   per-DUT queue. A monitor pops and compares one entry per clock edge.
// -----------------------------------------------------------------------------
module tb_regfile_multiport;

  logic clk;
  logic rst_a;
  logic rst_b;

  regfile_multiport_if #(.WIDTH(32), .DEPTH(32), .NUM_READ(2)) bus_a ();
  regfile_multiport_if #(.WIDTH(32), .DEPTH(20), .NUM_READ(3)) bus_b ();

  regfile_multiport #(
    .WIDTH(32), .DEPTH(32), .NUM_READ(2), .ZERO_REG(1), .BYPASS(1)
  ) dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (bus_a)
  );

  regfile_multiport #(
    .WIDTH(32), .DEPTH(20), .NUM_READ(3), .ZERO_REG(0), .BYPASS(0)
  ) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (bus_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------------------------------------------------------------------
  // Configuration of each DUT, as the reference model sees it
  // ---------------------------------------------------------------------------
  int cfg_depth [2] = '{32, 20};
  int cfg_nr    [2] = '{2, 3};
  int cfg_zero  [2] = '{1, 0};
  int cfg_byp   [2] = '{1, 0};

  // ---------------------------------------------------------------------------
  // Per-DUT stimulus for the coming edge
  // ---------------------------------------------------------------------------
  logic        s_rst   [2];
  logic        s_we    [2];
  logic [4:0]  s_waddr [2];
  logic [31:0] s_wdata [2];
  logic [2:0]  s_re    [2];
  logic [4:0]  s_raddr [2][3];
  logic        s_clr   [2];

  // ---------------------------------------------------------------------------
  // Reference model: array contents, remaining clear cycles, current read data
  // ---------------------------------------------------------------------------
  logic [31:0] m_mem   [2][32];
  int          m_left  [2];
  logic [95:0] m_rdata [2];

  typedef struct packed {
    logic [95:0] rdata;
    logic        busy;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  int tests = 0;
  int fails = 0;
  int cycle_no = 0;

  // One clock edge of the behavioural model. The clear zeroes the whole
  // array at once. Nothing can observe the entries until the clear finishes,
  // so only the remaining cycle count matters.
  function automatic exp_t model_step(input int k);
    exp_t  e;
    logic  wr_ok;
    int    a;
    logic [31:0] v;
    if (s_rst[k]) begin
      m_left[k]  = cfg_depth[k];
      m_rdata[k] = '0;
      for (int i = 0; i < 32; i++) m_mem[k][i] = '0;
    end else if (m_left[k] > 0) begin
      m_left[k]  = m_left[k] - 1;
      m_rdata[k] = '0;
    end else begin
      wr_ok = s_we[k] && (int'(s_waddr[k]) < cfg_depth[k]) &&
              !(cfg_zero[k] == 1 && s_waddr[k] == 5'd0) && !s_clr[k];
      for (int p = 0; p < cfg_nr[k]; p++) begin
        if (s_re[k][p]) begin
          a = int'(s_raddr[k][p]);
          if (a >= cfg_depth[k])                                  v = '0;
          else if (cfg_zero[k] == 1 && a == 0)                    v = '0;
          else if (cfg_byp[k] == 1 && wr_ok && a == int'(s_waddr[k])) v = s_wdata[k];
          else                                                    v = m_mem[k][a];
          m_rdata[k][p*32 +: 32] = v;
        end
      end
      if (wr_ok) m_mem[k][s_waddr[k]] = s_wdata[k];
      if (s_clr[k]) begin
        m_left[k] = cfg_depth[k];
        for (int i = 0; i < 32; i++) m_mem[k][i] = '0;
      end
    end
    e.rdata = m_rdata[k];
    e.busy  = (m_left[k] > 0);
    return e;
  endfunction

  // Drive the stimulus, predict the outcome, then wait for the next falling
  // edge. The rising edge in between consumes the inputs.
  task automatic cycle();
    rst_a           = s_rst[0];
    bus_a.we        = s_we[0];
    bus_a.waddr     = s_waddr[0];
    bus_a.wdata     = s_wdata[0];
    bus_a.re        = s_re[0][1:0];
    bus_a.raddr     = {s_raddr[0][1], s_raddr[0][0]};
    bus_a.clear_req = s_clr[0];

    rst_b           = s_rst[1];
    bus_b.we        = s_we[1];
    bus_b.waddr     = s_waddr[1];
    bus_b.wdata     = s_wdata[1];
    bus_b.re        = s_re[1];
    bus_b.raddr     = {s_raddr[1][2], s_raddr[1][1], s_raddr[1][0]};
    bus_b.clear_req = s_clr[1];

    q_a.push_back(model_step(0));
    q_b.push_back(model_step(1));
    @(negedge clk);
  endtask

  task automatic set_idle();
    for (int k = 0; k < 2; k++) begin
      s_rst[k] = 1'b0; s_we[k] = 1'b0; s_waddr[k] = '0; s_wdata[k] = '0;
      s_re[k] = '0; s_clr[k] = 1'b0;
      for (int p = 0; p < 3; p++) s_raddr[k][p] = '0;
    end
  endtask

  task automatic set_write(input logic [4:0] addr, input logic [31:0] data);
    for (int k = 0; k < 2; k++) begin
      s_we[k] = 1'b1; s_waddr[k] = addr; s_wdata[k] = data;
    end
  endtask

  task automatic set_read(input logic [2:0] re, input logic [4:0] a0,
                          input logic [4:0] a1, input logic [4:0] a2);
    for (int k = 0; k < 2; k++) begin
      s_re[k] = re; s_raddr[k][0] = a0; s_raddr[k][1] = a1; s_raddr[k][2] = a2;
    end
  endtask

  function automatic logic [4:0] rand_addr();
    // Half the traffic goes to a small window so forwarding hits are common.
    if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 7));
    return 5'($urandom_range(0, 31));
  endfunction

  task automatic set_random();
    for (int k = 0; k < 2; k++) begin
      s_rst[k]   = ($urandom_range(0, 599) == 0);
      s_clr[k]   = ($urandom_range(0, 149) == 0);
      s_we[k]    = ($urandom_range(0, 3) != 0);
      s_waddr[k] = rand_addr();
      s_wdata[k] = $urandom;
      s_re[k]    = 3'($urandom_range(0, 7));
      for (int p = 0; p < 3; p++) s_raddr[k][p] = rand_addr();
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: one expected entry per DUT per rising edge
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", name, cycle_no, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cycle_no++;
      if (q_a.size() > 0) begin
        e = q_a.pop_front();
        check("a_rdata", {32'd0, bus_a.rdata}, e.rdata);
        check("a_busy", {95'd0, bus_a.busy}, {95'd0, e.busy});
        $display("[MON] a cyc=%0d busy=%0b rdata=%h", cycle_no, bus_a.busy, bus_a.rdata);
      end
      if (q_b.size() > 0) begin
        e = q_b.pop_front();
        check("b_rdata", bus_b.rdata, e.rdata);
        check("b_busy", {95'd0, bus_b.busy}, {95'd0, e.busy});
        $display("[MON] b cyc=%0d busy=%0b rdata=%h", cycle_no, bus_b.busy, bus_b.rdata);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver
  // ---------------------------------------------------------------------------
  initial begin
    set_idle();

    // Reset, then hold a write to entry 5 through the whole clear.
    for (int k = 0; k < 2; k++) s_rst[k] = 1'b1;
    cycle();
    set_idle();
    set_write(5'd5, 32'h0000_DEAD);
    set_read(3'b001, 5'd5, 5'd0, 5'd0);
    repeat (32) cycle();
    set_idle();
    set_read(3'b111, 5'd5, 5'd5, 5'd5);
    cycle();

    // Write 7 while reading 7: forwarded on A, old value on B.
    set_idle();
    set_write(5'd7, 32'h0000_1234);
    set_read(3'b001, 5'd7, 5'd0, 5'd0);
    cycle();
    set_idle();
    set_read(3'b001, 5'd7, 5'd0, 5'd0);
    cycle();

    // Write all-ones to entry 0 and read it on every port, twice.
    set_idle();
    set_write(5'd0, 32'hFFFF_FFFF);
    set_read(3'b111, 5'd0, 5'd0, 5'd0);
    cycle();
    set_idle();
    set_read(3'b111, 5'd0, 5'd0, 5'd0);
    cycle();

    // Entries 1..3 = A, B, C. Then a masked read leaves port 1 untouched.
    for (int i = 1; i <= 3; i++) begin
      set_idle();
      set_write(5'(i), 32'(9 + i));
      cycle();
    end
    set_idle();
    set_read(3'b111, 5'd0, 5'd0, 5'd0);
    cycle();
    set_idle();
    set_read(3'b101, 5'd1, 5'd2, 5'd3);
    cycle();

    // Clear request, reset at ptr 10, full restart, then out-of-range access.
    set_idle();
    for (int k = 0; k < 2; k++) s_clr[k] = 1'b1;
    cycle();
    set_idle();
    repeat (10) cycle();
    for (int k = 0; k < 2; k++) s_rst[k] = 1'b1;
    cycle();
    set_idle();
    repeat (33) cycle();
    set_read(3'b111, 5'd25, 5'd25, 5'd25);
    cycle();
    set_idle();
    set_write(5'd25, 32'h5555_AAAA);
    cycle();
    set_idle();
    set_read(3'b111, 5'd25, 5'd19, 5'd25);
    cycle();

    // Random traffic.
    for (int n = 0; n < 1500; n++) begin
      set_random();
      cycle();
    end
    set_idle();
    cycle();

    // Let the monitor drain. The wait is bounded.
    for (int n = 0; n < 4 && (q_a.size() > 0 || q_b.size() > 0); n++) @(negedge clk);
    tests++;
    if (q_a.size() > 0 || q_b.size() > 0) begin
      fails++;
      $display("FAIL drain actual=%0d/%0d required=0/0", q_a.size(), q_b.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
